// File: rtl/axi_pack_conv_w.sv
// rtl/axi_pack_conv_w.sv - SSR-to-AXI write packing converter with descriptor queue
// Narrow SSR W elements are merged into wide AXI W beats as directed by queued descriptors.
package axi_pack_conv_w_pkg;
    typedef logic [7:0] len_t;

    typedef struct packed {
        logic [3:0] id;
        logic [2:0] ssr_offset;
        logic [5:0] std_offset;
        logic [2:0] ssr_size;
        len_t       ssr_stride;
        len_t       ssr_len;
        logic       same_size;
        logic       std_last;
    } sarq_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [3:0]  user;
    } ssr_w_chan_t;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  strb;
        logic         last;
        logic [3:0]   user;
    } w_chan_t;
endpackage

module axi_pack_conv_w #(
    parameter int unsigned DataWidth_S = 64,
    parameter int unsigned DataWidth_A = 512,
    parameter int unsigned FifoDepth   = 4,
    parameter type len_t            = axi_pack_conv_w_pkg::len_t,
    parameter type sarq_t           = axi_pack_conv_w_pkg::sarq_t,
    parameter type axi_ssr_w_chan_t = axi_pack_conv_w_pkg::ssr_w_chan_t,
    parameter type axi_w_chan_t     = axi_pack_conv_w_pkg::w_chan_t
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  sarq_t           wsarq_i,
    input  logic            wsarq_push,
    output logic            wsarq_full,
    input  axi_ssr_w_chan_t ssr_w_chan_i,
    input  logic            ssr_w_valid_i,
    output logic            ssr_w_ready_o,
    output axi_w_chan_t     w_chan_o,
    output logic            w_valid_o,
    input  logic            w_ready_i
);
    localparam int unsigned BytesS = DataWidth_S / 8;
    localparam int unsigned BytesA = DataWidth_A / 8;
    localparam int unsigned AlignS = $clog2(BytesS);
    localparam int unsigned AlignA = $clog2(BytesA);
    localparam int unsigned PtrW   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW   = $clog2(FifoDepth + 1);
    localparam int unsigned UserW  = $bits(w_chan_o.user);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] SEND  = 1'b1;

    sarq_t                  mem_q [FifoDepth];
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]        fill_q;
    sarq_t                  head;
    logic                   empty, q_full, id_block, push_en, pop;

    logic [0:0]             state_q, state_d;
    len_t                   in_cnt_q, in_cnt_d;
    logic [AlignA-1:0]      out_cnt_q, out_cnt_d;
    logic [DataWidth_A-1:0] data_q, data_d;
    logic [BytesA-1:0]      strb_q, strb_d;
    logic                   final_q, final_d, last_q, last_d;
    logic [UserW-1:0]       user_q, user_d;

    logic                   ssr_hs, w_hs, is_final, flush;
    logic [AlignS-1:0]      in_off, src;
    logic [AlignA-1:0]      out_off, out_step, lane_rel;
    logic [AlignA:0]        nbytes, step_wide, next_start;
    logic                   unused_last;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // A descriptor from a different burst id must wait until the current head drains.
    assign head       = mem_q[rd_ptr_q];
    assign empty      = (fill_q == '0);
    assign q_full     = (fill_q == CntW'(FifoDepth));
    assign id_block   = ~empty & (wsarq_i.id != head.id);
    assign wsarq_full = q_full | id_block;
    assign push_en    = wsarq_push & ~wsarq_full;
    assign pop        = w_hs & final_q;

    assign ssr_w_ready_o = (state_q == ACCUM) & ~empty;
    assign w_valid_o     = (state_q == SEND);
    assign ssr_hs        = ssr_w_valid_i & ssr_w_ready_o;
    assign w_hs          = w_valid_o & w_ready_i;
    assign unused_last   = ssr_w_chan_i.last;

    assign in_off     = AlignS'(head.ssr_offset + (AlignS'(in_cnt_q) << head.ssr_size));
    assign out_off    = AlignA'(head.std_offset + (out_cnt_q << head.ssr_size));
    assign out_step   = AlignA'(head.ssr_stride + 1);
    assign nbytes     = (AlignA+1)'(1) << head.ssr_size;
    assign step_wide  = (AlignA+1)'((head.ssr_stride + 1) << head.ssr_size);
    assign next_start = {1'b0, out_off} + step_wide;
    assign is_final   = (in_cnt_q == head.ssr_len);
    assign flush      = head.same_size | is_final | next_start[AlignA];

    always_comb begin
        data_d   = data_q;
        strb_d   = strb_q;
        lane_rel = '0;
        src      = '0;
        if (w_hs) begin
            data_d = '0;
            strb_d = '0;
        end else if (ssr_hs) begin
            for (int j = 0; j < BytesA; j++) begin
                lane_rel = AlignA'(j) - out_off;
                if ({1'b0, lane_rel} < nbytes) begin
                    src                = in_off + AlignS'(lane_rel);
                    data_d[j*8 +: 8]   = ssr_w_chan_i.data[src*8 +: 8];
                    strb_d[j]          = strb_q[j] | ssr_w_chan_i.strb[src];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        final_d   = final_q;
        last_d    = last_q;
        user_d    = user_q;
        if (state_q == ACCUM) begin
            if (ssr_hs) begin
                in_cnt_d = in_cnt_q + 1'b1;
                // Same-size elements are whole AXI beats, so they always land at std_offset.
                if (!head.same_size) out_cnt_d = out_cnt_q + out_step;
                user_d = ssr_w_chan_i.user;
                if (flush) begin
                    state_d = SEND;
                    final_d = is_final;
                    last_d  = is_final & head.std_last;
                end
            end
        end else if (w_ready_i) begin
            state_d = ACCUM;
            final_d = 1'b0;
            if (final_q) begin
                in_cnt_d  = '0;
                out_cnt_d = '0;
            end
        end
        if (empty) begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
        end
    end

    always_comb begin
        w_chan_o = '0;
        if (state_q == SEND) begin
            w_chan_o.data = data_q;
            w_chan_o.strb = strb_q;
            w_chan_o.last = last_q;
            w_chan_o.user = user_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            state_q   <= ACCUM;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            final_q   <= 1'b0;
            last_q    <= 1'b0;
            user_q    <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= wsarq_i;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_next(rd_ptr_q);
            case ({push_en, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            final_q   <= final_d;
            last_q    <= last_d;
            user_q    <= user_d;
        end
    end
endmodule

// File: tb/tb_axi_pack_conv_w.sv
// tb/tb_axi_pack_conv_w.sv - scoreboard testbench for axi_pack_conv_w
module tb_axi_pack_conv_w;
    import axi_pack_conv_w_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    sarq_t       wsarq;
    logic        wsarq_push, wsarq_full;
    ssr_w_chan_t ssr_chan;
    logic        ssr_valid, ssr_ready;
    w_chan_t     w_chan;
    logic        w_valid, w_ready;

    int          n_run = 0;
    int          n_fail = 0;
    w_chan_t     exp_q[$];
    w_chan_t     mon_exp, exp_a, exp_b;
    logic [511:0] eb;

    always #5 clk = ~clk;

    axi_pack_conv_w dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .wsarq_i       (wsarq),
        .wsarq_push    (wsarq_push),
        .wsarq_full    (wsarq_full),
        .ssr_w_chan_i  (ssr_chan),
        .ssr_w_valid_i (ssr_valid),
        .ssr_w_ready_o (ssr_ready),
        .w_chan_o      (w_chan),
        .w_valid_o     (w_valid),
        .w_ready_i     (w_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic sarq_t mk_desc(input logic [3:0] id, input logic [5:0] std_off,
                                      input logic [2:0] size, input logic [7:0] stride,
                                      input logic [7:0] len, input logic same, input logic slast);
        sarq_t d;
        d            = '0;
        d.id         = id;
        d.std_offset = std_off;
        d.ssr_size   = size;
        d.ssr_stride = stride;
        d.ssr_len    = len;
        d.same_size  = same;
        d.std_last   = slast;
        return d;
    endfunction

    function automatic w_chan_t mk_beat(input logic [511:0] d, input logic [63:0] s,
                                        input logic l, input logic [3:0] u);
        w_chan_t b;
        b.data = d;
        b.strb = s;
        b.last = l;
        b.user = u;
        return b;
    endfunction

    task automatic push_desc(input sarq_t d);
        wsarq      = d;
        wsarq_push = 1'b1;
        @(posedge clk); #1;
        wsarq_push = 1'b0;
    endtask

    // Places element k on the SSR lanes its size and index select, then waits for acceptance.
    task automatic ssr_elem(input int size, input int k, input logic [63:0] val, input logic [3:0] user);
        int lane, nb, t;
        lane = (k << size) % 8;
        nb   = 1 << size;
        ssr_chan      = '0;
        ssr_chan.data = val << (8 * lane);
        ssr_chan.strb = 8'(((1 << nb) - 1) << lane);
        ssr_chan.user = user;
        ssr_valid     = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (ssr_ready) break;
            t++;
            if (t > 50) begin
                n_run++;
                n_fail++;
                $display("FAIL ssr_ready_timeout: got ready=0 for 50 cycles, expected 1");
                break;
            end
        end
        @(posedge clk); #1;
        ssr_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && w_valid && w_ready) begin
            n_run++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL w_beat_unexpected: got strb=%h last=%b, expected no beat", w_chan.strb, w_chan.last);
            end else begin
                mon_exp = exp_q.pop_front();
                if (w_chan !== mon_exp) begin
                    n_fail++;
                    $display("FAIL w_beat: got data=%h strb=%h last=%b user=%h expected data=%h strb=%h last=%b user=%h",
                             w_chan.data, w_chan.strb, w_chan.last, w_chan.user,
                             mon_exp.data, mon_exp.strb, mon_exp.last, mon_exp.user);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        wsarq      = '0;
        wsarq_push = 1'b0;
        ssr_chan   = '0;
        ssr_valid  = 1'b0;
        w_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_w_valid", 64'(w_valid), 64'd0);
        check("rst_ssr_ready", 64'(ssr_ready), 64'd0);
        check("rst_w_chan_zero", 64'(|w_chan), 64'd0);
        check("rst_wsarq_full", 64'(wsarq_full), 64'd0);
        @(posedge clk); #1;

        // Same size: four full-lane beats, last only on the final one
        push_desc(mk_desc(4'd0, 6'd0, 3'd3, 8'd0, 8'd3, 1'b1, 1'b1));
        for (int k = 0; k < 4; k++) begin
            eb = '0;
            eb[63:0] = 64'hC0DE_0000_0000_0000 | 64'(k);
            exp_q.push_back(mk_beat(eb, 64'hFF, (k == 3), 4'(k)));
            ssr_elem(3, k, 64'hC0DE_0000_0000_0000 | 64'(k), 4'(k));
        end
        drain("same_size");

        // Dense packing: sixteen 4-byte elements fill one beat
        push_desc(mk_desc(4'd0, 6'd0, 3'd2, 8'd0, 8'd15, 1'b0, 1'b1));
        eb = '0;
        for (int k = 0; k < 16; k++) eb[32*k +: 32] = 32'hD000_0000 + 32'(k * 257);
        exp_q.push_back(mk_beat(eb, {64{1'b1}}, 1'b1, 4'd15));
        for (int k = 0; k < 16; k++) ssr_elem(2, k, 64'(32'hD000_0000 + 32'(k * 257)), 4'(k));
        drain("dense");

        // Strided: 8-byte elements every 16 bytes
        push_desc(mk_desc(4'd0, 6'd0, 3'd3, 8'd1, 8'd7, 1'b0, 1'b1));
        for (int b = 0; b < 2; b++) begin
            eb = '0;
            for (int j = 0; j < 4; j++) eb[128*j +: 64] = 64'h5700_0000_0000_0000 + 64'(4*b + j);
            exp_q.push_back(mk_beat(eb, 64'h00FF_00FF_00FF_00FF, (b == 1), 4'(4*b + 3)));
        end
        for (int k = 0; k < 8; k++) ssr_elem(3, k, 64'h5700_0000_0000_0000 + 64'(k), 4'(k));
        drain("strided");

        // Word crossing: start at byte 56, spill into a second beat
        push_desc(mk_desc(4'd0, 6'd56, 3'd2, 8'd0, 8'd3, 1'b0, 1'b1));
        eb = '0;
        eb[448 +: 32] = 32'hE000_0000;
        eb[480 +: 32] = 32'hE000_0001;
        exp_q.push_back(mk_beat(eb, 64'hFF00_0000_0000_0000, 1'b0, 4'd1));
        eb = '0;
        eb[0 +: 32]  = 32'hE000_0002;
        eb[32 +: 32] = 32'hE000_0003;
        exp_q.push_back(mk_beat(eb, 64'hFF, 1'b1, 4'd3));
        for (int k = 0; k < 4; k++) ssr_elem(2, k, 64'(32'hE000_0000 + 32'(k)), 4'(k));
        drain("crossing");

        // Backpressure: beat held stable for five cycles, then accepted
        push_desc(mk_desc(4'd3, 6'd0, 3'd3, 8'd0, 8'd0, 1'b1, 1'b1));
        push_desc(mk_desc(4'd3, 6'd0, 3'd3, 8'd0, 8'd0, 1'b1, 1'b1));
        w_ready = 1'b0;
        eb = '0;
        eb[63:0] = 64'hBADC_0FFE_0000_0001;
        exp_a = mk_beat(eb, 64'hFF, 1'b1, 4'd7);
        exp_q.push_back(exp_a);
        ssr_elem(3, 0, 64'hBADC_0FFE_0000_0001, 4'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_w_valid", 64'(w_valid), 64'd1);
            check("bp_ssr_ready", 64'(ssr_ready), 64'd0);
            check("bp_w_chan_stable", 64'(w_chan !== exp_a), 64'd0);
        end
        @(posedge clk); #1 w_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_accum_resume", 64'(ssr_ready), 64'd1);
        check("bp_w_valid_low", 64'(w_valid), 64'd0);
        @(posedge clk); #1;
        eb = '0;
        eb[63:0] = 64'h0000_0000_1234_5678;
        exp_b = mk_beat(eb, 64'hFF, 1'b1, 4'd2);
        exp_q.push_back(exp_b);
        ssr_elem(3, 0, 64'h0000_0000_1234_5678, 4'd2);
        drain("backpressure");

        // ID isolation: a different id is held off until the head burst completes
        push_desc(mk_desc(4'd1, 6'd0, 3'd3, 8'd0, 8'd0, 1'b1, 1'b1));
        wsarq      = mk_desc(4'd2, 6'd0, 3'd3, 8'd0, 8'd0, 1'b1, 1'b1);
        wsarq_push = 1'b1;
        @(negedge clk);
        check("iso_full_forced", 64'(wsarq_full), 64'd1);
        @(posedge clk); #1 wsarq_push = 1'b0;
        eb = '0;
        eb[63:0] = 64'h1111_0000_0000_0001;
        exp_q.push_back(mk_beat(eb, 64'hFF, 1'b1, 4'd1));
        ssr_elem(3, 0, 64'h1111_0000_0000_0001, 4'd1);
        drain("iso_id1");
        @(negedge clk);
        check("iso_not_enqueued", 64'(ssr_ready), 64'd0);
        check("iso_full_released", 64'(wsarq_full), 64'd0);
        @(posedge clk); #1;
        push_desc(mk_desc(4'd2, 6'd0, 3'd3, 8'd0, 8'd0, 1'b1, 1'b1));
        eb = '0;
        eb[63:0] = 64'h2222_0000_0000_0002;
        exp_q.push_back(mk_beat(eb, 64'hFF, 1'b1, 4'd2));
        ssr_elem(3, 0, 64'h2222_0000_0000_0002, 4'd2);
        drain("iso_id2");

        // Asynchronous reset in the middle of a burst
        push_desc(mk_desc(4'd4, 6'd0, 3'd3, 8'd0, 8'd1, 1'b1, 1'b1));
        w_ready = 1'b0;
        ssr_elem(3, 0, 64'hDEAD_BEEF_0000_0004, 4'd4);
        wsarq = mk_desc(4'd5, 6'd0, 3'd3, 8'd0, 8'd0, 1'b1, 1'b1);
        @(negedge clk);
        check("pre_rst_w_valid", 64'(w_valid), 64'd1);
        check("pre_rst_full", 64'(wsarq_full), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_w_valid", 64'(w_valid), 64'd0);
        check("async_rst_ssr_ready", 64'(ssr_ready), 64'd0);
        check("async_rst_w_chan", 64'(|w_chan), 64'd0);
        check("async_rst_full", 64'(wsarq_full), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst     = 1'b0;
        w_ready = 1'b1;
        @(negedge clk);
        check("rst_queue_flushed", 64'(ssr_ready), 64'd0);
        check("rst_no_w_valid", 64'(w_valid), 64'd0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
